// File: rtl/rv32i_amo_unit.sv
// rtl/rv32i_amo_unit.sv - RISC-V A-extension atomic memory operation unit
// Executes AMO read-modify-write, LR and SC against a single-port data memory.
module rv32i_amo_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_funct5,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_src,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr
);

  localparam int AL = (XLEN == 64) ? 3 : 2;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state;
  logic [4:0]        funct5_q;
  logic [XLEN-1:0]   src_q;
  logic [XLEN-1:0]   old_q;
  logic              resv_valid;
  logic [ADDR_W-1:0] resv_addr;
  logic              supported;
  logic              misaligned;
  logic              snoop_hit;
  logic              sc_ok;
  logic [XLEN-1:0]   amo_result;

  assign req_ready  = (state == IDLE);
  assign misaligned = |req_addr[AL-1:0];
  assign snoop_hit  = snoop_we && resv_valid && (snoop_addr == resv_addr);
  // A snoop landing in the SC acceptance cycle already invalidates the reservation.
  assign sc_ok      = resv_valid && (resv_addr == req_addr) && !snoop_hit;

  always_comb begin
    supported = 1'b0;
    case (req_funct5)
      F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
      F_MIN, F_MAX, F_MINU, F_MAXU: supported = 1'b1;
      default:                      supported = 1'b0;
    endcase
  end

  always_comb begin
    amo_result = src_q;
    case (funct5_q)
      F_ADD:   amo_result = mem_rdata + src_q;
      F_XOR:   amo_result = mem_rdata ^ src_q;
      F_OR:    amo_result = mem_rdata | src_q;
      F_AND:   amo_result = mem_rdata & src_q;
      F_MIN:   amo_result = ($signed(mem_rdata) < $signed(src_q)) ? mem_rdata : src_q;
      F_MAX:   amo_result = ($signed(mem_rdata) > $signed(src_q)) ? mem_rdata : src_q;
      F_MINU:  amo_result = (mem_rdata < src_q) ? mem_rdata : src_q;
      F_MAXU:  amo_result = (mem_rdata > src_q) ? mem_rdata : src_q;
      default: amo_result = src_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      funct5_q   <= '0;
      src_q      <= '0;
      old_q      <= '0;
      resv_valid <= 1'b0;
      resv_addr  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (snoop_hit) resv_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            funct5_q <= req_funct5;
            src_q    <= req_src;
            mem_addr <= req_addr;
            if (req_funct5 == F_SC) resv_valid <= 1'b0;
            if (!supported || misaligned) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else if (req_funct5 == F_SC) begin
              if (sc_ok) begin
                state     <= WR;
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_wdata <= req_src;
                old_q     <= '0;
              end else begin
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_data  <= {{(XLEN-1){1'b0}}, 1'b1};
              end
            end else begin
              state   <= RD;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            old_q <= mem_rdata;
            if (funct5_q == F_LR) begin
              resv_valid <= 1'b1;
              resv_addr  <= mem_addr;
              mem_req    <= 1'b0;
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= mem_rdata;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= amo_result;
              state     <= WR;
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= old_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_amo_unit.sv
// tb/tb_rv32i_amo_unit.sv - scoreboard bench for rv32i_amo_unit
module tb_rv32i_amo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_funct5 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_src = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        snoop_we = 1'b0;
  logic [31:0] snoop_addr = '0;

  rv32i_amo_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
    .req_addr(req_addr), .req_src(req_src),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int memreq_cnt = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with programmable wait states; ack may be combinational with req.
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_req && mem_ack) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      wait_cnt <= 0;
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) memreq_cnt++;
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_err", resp_err, e.err);
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Memory-interface stability while an access waits for ack
  logic        p_pending = 1'b0;
  logic [1:0]  p_ctl;
  logic [31:0] p_addr, p_wdata;
  always @(negedge clk) begin
    if (rst) begin
      p_pending = 1'b0;
    end else begin
      if (p_pending) begin
        chk("hold_ctl", {mem_req, mem_we}, p_ctl);
        chk("hold_addr", mem_addr, p_addr);
        chk("hold_wdata", mem_wdata, p_wdata);
      end
      p_pending = mem_req && !mem_ack;
      p_ctl     = {mem_req, mem_we};
      p_addr    = mem_addr;
      p_wdata   = mem_wdata;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = a[9:2]; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] ed, input logic ee, input int el,
                       input bit push, input bit snp);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    req_valid = 1'b1; req_funct5 = f; req_addr = a; req_src = s;
    if (snp) begin snoop_we = 1'b1; snoop_addr = a; end
    if (push) sb.push_back('{data: ed, err: ee, lat: el, acc: cyc});
    @(posedge clk); #1;
    req_valid = 1'b0;
    snoop_we  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", sb.size(), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_mem(input string name, input logic [31:0] a, input logic [31:0] d);
    chk(name, mem[a[9:2]], d);
  endtask

  int mr0;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    #2 rst = 1'b0;

    // AMOADD wrap
    preload(32'h100, 32'h7FFF_FFFF);
    issue(5'b00000, 32'h100, 32'd1, 32'h7FFF_FFFF, 1'b0, 3, 1, 0);
    wait_done();
    chk_mem("add_mem", 32'h100, 32'h8000_0000);

    // Signed vs unsigned min
    preload(32'h40, 32'hFFFF_FFFE);
    issue(5'b10000, 32'h40, 32'd1, 32'hFFFF_FFFE, 1'b0, 3, 1, 0);
    wait_done();
    chk_mem("min_mem", 32'h40, 32'hFFFF_FFFE);
    issue(5'b11000, 32'h40, 32'd1, 32'hFFFF_FFFE, 1'b0, 3, 1, 0);
    wait_done();
    chk_mem("minu_mem", 32'h40, 32'h0000_0001);

    // Logic ops, MAX/MAXU, SWAP chained on one word
    preload(32'h20, 32'hF0F0_F0F0);
    issue(5'b00100, 32'h20, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, 3, 1, 0); wait_done();
    chk_mem("xor_mem", 32'h20, 32'h0FF0_0FF0);
    issue(5'b01000, 32'h20, 32'h0000_000F, 32'h0FF0_0FF0, 1'b0, 3, 1, 0); wait_done();
    chk_mem("or_mem", 32'h20, 32'h0FF0_0FFF);
    issue(5'b01100, 32'h20, 32'hFFFF_0000, 32'h0FF0_0FFF, 1'b0, 3, 1, 0); wait_done();
    chk_mem("and_mem", 32'h20, 32'h0FF0_0000);
    issue(5'b10100, 32'h20, 32'h8000_0000, 32'h0FF0_0000, 1'b0, 3, 1, 0); wait_done();
    chk_mem("max_mem", 32'h20, 32'h0FF0_0000);
    issue(5'b11100, 32'h20, 32'h8000_0000, 32'h0FF0_0000, 1'b0, 3, 1, 0); wait_done();
    chk_mem("maxu_mem", 32'h20, 32'h8000_0000);
    issue(5'b00001, 32'h20, 32'h1234_5678, 32'h8000_0000, 1'b0, 3, 1, 0); wait_done();
    chk_mem("swap_mem", 32'h20, 32'h1234_5678);

    // LR / SC success / SC without reservation
    preload(32'h80, 32'h0000_0011);
    issue(5'b00010, 32'h80, 32'd0, 32'h0000_0011, 1'b0, 2, 1, 0); wait_done();
    issue(5'b00011, 32'h80, 32'd5, 32'd0, 1'b0, 2, 1, 0); wait_done();
    chk_mem("sc_ok_mem", 32'h80, 32'd5);
    mr0 = memreq_cnt;
    issue(5'b00011, 32'h80, 32'd7, 32'd1, 1'b0, 1, 1, 0); wait_done();
    chk("sc2_no_memreq", memreq_cnt - mr0, 0);
    chk_mem("sc2_mem", 32'h80, 32'd5);

    // Snoop between LR and SC
    issue(5'b00010, 32'h80, 32'd0, 32'd5, 1'b0, 2, 1, 0); wait_done();
    @(negedge clk); snoop_we = 1'b1; snoop_addr = 32'h80;
    @(posedge clk); #1 snoop_we = 1'b0;
    mr0 = memreq_cnt;
    issue(5'b00011, 32'h80, 32'd9, 32'd1, 1'b0, 1, 1, 0); wait_done();
    chk("snoop_sc_no_memreq", memreq_cnt - mr0, 0);
    chk_mem("snoop_sc_mem", 32'h80, 32'd5);

    // Snoop in the same cycle as SC acceptance
    issue(5'b00010, 32'h80, 32'd0, 32'd5, 1'b0, 2, 1, 0); wait_done();
    issue(5'b00011, 32'h80, 32'd9, 32'd1, 1'b0, 1, 1, 1); wait_done();
    chk_mem("snoop_same_mem", 32'h80, 32'd5);

    // Misaligned and unsupported
    mr0 = memreq_cnt;
    issue(5'b00001, 32'h102, 32'd3, 32'd0, 1'b1, 1, 1, 0); wait_done();
    issue(5'b00101, 32'h100, 32'd3, 32'd0, 1'b1, 1, 1, 0); wait_done();
    chk("err_no_memreq", memreq_cnt - mr0, 0);
    chk_mem("err_mem", 32'h100, 32'h8000_0000);

    // Four wait states in both RD and WR
    ack_delay = 4;
    preload(32'h60, 32'd10);
    issue(5'b00000, 32'h60, 32'd3, 32'd10, 1'b0, 11, 1, 0); wait_done();
    chk_mem("delay_mem", 32'h60, 32'd13);

    // Reset while waiting in WR
    ack_delay = 20;
    issue(5'b00000, 32'h60, 32'd3, 32'd0, 1'b0, 0, 0, 0);
    begin
      int n;
      n = 0;
      while (!(mem_req && mem_we) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("reached_wr", {mem_req, mem_we}, 2'b11);
    end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_wr_mem_req", mem_req, 0);
    chk("rst_wr_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    ack_delay = 0;
    repeat (10) @(negedge clk);
    chk_mem("rst_wr_mem", 32'h60, 32'd13);
    chk("rst_wr_mem_req_after", mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_amo_unit.md
RV32I_AMO_UNIT -- requirements
Module: rv32i_amo_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data word width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1, meaning an atomic request is presented.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-007 The block SHALL have port req_funct5, input, 5, meaning the RISC-V A-extension funct5 field.
REQ-008 The block SHALL have port req_addr, input, ADDR_W, meaning the rs1 byte address.
REQ-009 The block SHALL have port req_src, input, XLEN, meaning the rs2 operand.
REQ-010 The block SHALL have port resp_valid, output, 1, meaning a one-cycle response pulse.
REQ-011 The block SHALL have port resp_data, output, XLEN, meaning the rd write value.
REQ-012 The block SHALL have port resp_err, output, 1, meaning the request was misaligned or unsupported; valid only with resp_valid.
REQ-013 The block SHALL have port mem_req, output, 1, meaning a data-memory access is requested.
REQ-014 The block SHALL have port mem_we, output, 1, meaning the access is a write (1) or a read (0).
REQ-015 The block SHALL have ports mem_addr, output, ADDR_W, and mem_wdata, output, XLEN, meaning the access address and write data.
REQ-016 The block SHALL have ports mem_ack, input, 1, and mem_rdata, input, XLEN, meaning access completion and read data valid in the ack cycle.
REQ-017 The block SHALL have ports snoop_we, input, 1, and snoop_addr, input, ADDR_W, meaning a store by another agent.

Function
REQ-018 Supported funct5 codes SHALL be: ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
REQ-019 The FSM states SHALL be IDLE, RD, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted when req_valid and req_ready are both 1; funct5, addr and src are latched at acceptance.
REQ-021 Misaligned requests (low log2(XLEN/8) address bits nonzero) and unsupported funct5 codes SHALL go IDLE->RESP with resp_err=1, resp_data=0, and no memory access.
REQ-022 AMO ops SHALL follow IDLE->RD->WR->RESP; RD issues a read of the latched address and waits for mem_ack, capturing old=mem_rdata.
REQ-023 In WR the block SHALL write f(old, src) with mem_we=1, holding mem_req, mem_addr and mem_wdata stable until mem_ack; resp_data SHALL be old.
REQ-024 f SHALL be: ADD, old+src modulo 2^XLEN; SWAP, src; XOR/OR/AND, bitwise; MIN/MAX, signed compare; MINU/MAXU, unsigned compare.
REQ-025 LR SHALL follow IDLE->RD->RESP, return old, and set the reservation (valid=1, address=latched addr).
REQ-026 SC SHALL go to WR writing src and return 0 if the reservation is valid and its address matches; otherwise it SHALL go IDLE->RESP, return 1, and make no memory access. Either way, SC SHALL clear the reservation.
REQ-027 snoop_we with snoop_addr equal to the reservation address SHALL clear the reservation in that cycle; a snoop that coincides with SC acceptance SHALL make the SC fail.
REQ-028 mem_ack SHALL be honoured in the same cycle mem_req rises; wait states are unbounded; mem_ack outside RD/WR SHALL be ignored.
REQ-029 resp_valid SHALL be high for exactly one cycle in RESP, followed by IDLE; there is no response backpressure.
REQ-030 Minimum latency with zero-wait memory SHALL be: AMO, resp_valid 3 cycles after acceptance; LR/SC-success, 2 cycles; error/SC-fail, 1 cycle.

Reset
REQ-031 While rst=1: state=IDLE; reservation invalid; req_ready=1; resp_valid, resp_err, mem_req and mem_we are 0; resp_data, mem_addr and mem_wdata are 0.
REQ-032 Reset mid-operation SHALL abandon the access immediately, deassert mem_req, and produce no response.

Verification
REQ-033 Memory at 0x100 holds 0x7FFFFFFF; AMOADD with src=1 -> memory becomes 0x80000000, resp_data=0x7FFFFFFF, resp_valid at acceptance+3.
REQ-034 Memory at 0x40 holds 0xFFFFFFFE; AMOMIN with src=1 -> memory keeps 0xFFFFFFFE; AMOMINU with src=1 -> memory becomes 0x00000001.
REQ-035 LR 0x80 then SC 0x80 with src=5 -> SC resp_data=0 and memory becomes 5; a second SC -> resp_data=1 and no mem_req.
REQ-036 LR 0x80, then snoop_we to 0x80, then SC -> resp_data=1 and memory unchanged.
REQ-037 AMOSWAP at 0x102 -> resp_err=1 one cycle after acceptance, with no mem_req; funct5=00101 -> resp_err=1.
REQ-038 mem_ack delayed 4 cycles in both RD and WR -> mem_* held stable throughout; rst asserted in WR -> mem_req=0 immediately and no resp_valid.
